// File: rtl/rvfi_check_sequencer_if.sv
// rtl/rvfi_check_sequencer_if.sv - handshake bundle between check harness and sequencer
// master = harness side (drives enable/retire channels); slave = sequencer.
interface rvfi_check_sequencer_if #(
  parameter int NRET  = 1,
  parameter int CNT_W = 8
);
  logic             enable;
  logic [NRET-1:0]  rvfi_valid;
  logic [NRET-1:0]  rvfi_halt;
  logic             core_reset;
  logic             trig;
  logic             check;
  logic [CNT_W-1:0] cycle;
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] idle_cnt;
  logic             hang;
  logic             halted;
  logic             done;

  modport master (
    output enable, rvfi_valid, rvfi_halt,
    input  core_reset, trig, check, cycle, retired, idle_cnt, hang, halted, done
  );

  modport slave (
    input  enable, rvfi_valid, rvfi_halt,
    output core_reset, trig, check, cycle, retired, idle_cnt, hang, halted, done
  );
endinterface

// File: rtl/rvfi_check_sequencer.sv
// rtl/rvfi_check_sequencer.sv - reset/run/trigger/check sequencer for rvfi checkers
// Holds the core in reset, runs it, strobes trig/check, tracks retirements, hangs and halts.
module rvfi_check_sequencer #(
  parameter int NRET         = 1,
  parameter int RESET_CYCLES = 2,
  parameter int TRIG_CYCLE   = 4,
  parameter int CHECK_CYCLE  = 8,
  parameter int HANG_LIMIT   = 5,
  parameter int CNT_W        = 8
) (
  input logic                   clock,
  input logic                   reset,
  rvfi_check_sequencer_if.slave bus
);

  if (NRET < 1 || RESET_CYCLES < 1 || TRIG_CYCLE < 0 || CHECK_CYCLE <= TRIG_CYCLE ||
      HANG_LIMIT < 1 || CHECK_CYCLE >= (1 << CNT_W) || HANG_LIMIT >= (1 << CNT_W) ||
      RESET_CYCLES >= (1 << CNT_W)) begin : g_bad_params
    $error("rvfi_check_sequencer: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_rst_cnt;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_idle;
  logic             r_core_reset;
  logic             r_hang;
  logic             r_halted;
  logic             r_done;

  logic [CNT_W:0]   w_pop;
  logic [CNT_W:0]   w_ret_sum;
  logic [CNT_W-1:0] w_ret_next;
  logic [CNT_W-1:0] w_idle_next;
  logic             w_any_valid;
  logic             w_halt_hit;
  logic             w_trig;
  logic             w_check;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NRET; i++) begin
      w_pop = w_pop + {{CNT_W{1'b0}}, bus.rvfi_valid[i]};
    end
  end

  // Carry out of the widened sum means the count would pass all-ones.
  assign w_ret_sum   = {1'b0, r_retired} + w_pop;
  assign w_ret_next  = w_ret_sum[CNT_W] ? MAX_CNT : w_ret_sum[CNT_W-1:0];
  assign w_any_valid = |bus.rvfi_valid;
  assign w_halt_hit  = |(bus.rvfi_valid & bus.rvfi_halt);
  assign w_idle_next = w_any_valid ? '0 : ((r_idle == MAX_CNT) ? MAX_CNT : r_idle + CNT_W'(1));

  assign w_trig  = (r_state == S_RUN) && (r_cycle == CNT_W'(TRIG_CYCLE));
  assign w_check = (r_state == S_RUN) && (r_cycle == CNT_W'(CHECK_CYCLE));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rst_cnt    <= '0;
      r_cycle      <= '0;
      r_retired    <= '0;
      r_idle       <= '0;
      r_core_reset <= 1'b1;
      r_hang       <= 1'b0;
      r_halted     <= 1'b0;
      r_done       <= 1'b0;
    end else if (!bus.enable) begin
      r_state      <= S_IDLE;
      r_rst_cnt    <= '0;
      r_cycle      <= '0;
      r_retired    <= '0;
      r_idle       <= '0;
      r_core_reset <= 1'b1;
      r_hang       <= 1'b0;
      r_halted     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state   <= S_RST;
          r_rst_cnt <= '0;
        end
        S_RST: begin
          r_rst_cnt <= r_rst_cnt + CNT_W'(1);
          if (r_rst_cnt == CNT_W'(RESET_CYCLES - 1)) begin
            r_state      <= S_RUN;
            r_cycle      <= '0;
            r_core_reset <= 1'b0;
          end
        end
        S_RUN: begin
          r_retired <= w_ret_next;
          r_idle    <= w_idle_next;
          if (w_idle_next == CNT_W'(HANG_LIMIT)) r_hang <= 1'b1;
          if (w_halt_hit) r_halted <= 1'b1;
          // cycle freezes at the exit index so it can never wrap
          if (w_halt_hit || w_check) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cycle <= r_cycle + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_DONE;
        end
      endcase
    end
  end

  assign bus.core_reset = r_core_reset;
  assign bus.trig       = w_trig;
  assign bus.check      = w_check;
  assign bus.cycle      = r_cycle;
  assign bus.retired    = r_retired;
  assign bus.idle_cnt   = r_idle;
  assign bus.hang       = r_hang;
  assign bus.halted     = r_halted;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// tb/tb_rvfi_check_sequencer.sv - directed self-checking bench for rvfi_check_sequencer
// Main instance uses the default timing; a narrow CNT_W=4 instance covers retire saturation.
module tb_rvfi_check_sequencer;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  rvfi_check_sequencer_if #(.NRET(2), .CNT_W(8)) bus ();
  rvfi_check_sequencer_if #(.NRET(2), .CNT_W(4)) bus2 ();

  rvfi_check_sequencer #(
    .NRET(2), .RESET_CYCLES(2), .TRIG_CYCLE(4), .CHECK_CYCLE(8), .HANG_LIMIT(5), .CNT_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  rvfi_check_sequencer #(
    .NRET(2), .RESET_CYCLES(2), .TRIG_CYCLE(4), .CHECK_CYCLE(10), .HANG_LIMIT(5), .CNT_W(4)
  ) dut_sat (
    .clock(clock),
    .reset(reset),
    .bus  (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // enable is raised after an edge; core_reset stays high two more edges and drops on the third
  task automatic start_seq(input string tag);
    bus.enable = 1'b1;
    step();
    chk({tag, "_crst_e1"}, bus.core_reset, 1);
    step();
    chk({tag, "_crst_e2"}, bus.core_reset, 1);
    step();
    chk({tag, "_crst_e3"}, bus.core_reset, 0);
    chk({tag, "_cycle0"}, bus.cycle, 0);
  endtask

  task automatic go_run(input string tag, input logic [1:0] v);
    for (int c = 0; c <= 8; c++) begin
      chk({tag, "_cycle"}, bus.cycle, c);
      chk({tag, "_trig"}, bus.trig, (c == 4) ? 1 : 0);
      chk({tag, "_check"}, bus.check, (c == 8) ? 1 : 0);
      bus.rvfi_valid = v;
      step();
    end
    bus.rvfi_valid = 2'b00;
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_check_after"}, bus.check, 0);
    chk({tag, "_trig_after"}, bus.trig, 0);
  endtask

  task automatic to_idle(input string tag);
    bus.enable = 1'b0;
    bus.rvfi_valid = 2'b00;
    bus.rvfi_halt  = 2'b00;
    step();
    chk({tag, "_idle_crst"}, bus.core_reset, 1);
    chk({tag, "_idle_done"}, bus.done, 0);
    chk({tag, "_idle_ret"}, bus.retired, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.rvfi_valid = 2'b00;
    bus.rvfi_halt  = 2'b00;
    bus2.enable = 1'b0;
    bus2.rvfi_valid = 2'b00;
    bus2.rvfi_halt  = 2'b00;
    step();
    chk("rst_core_reset", bus.core_reset, 1);
    chk("rst_trig", bus.trig, 0);
    chk("rst_check", bus.check, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hang", bus.hang, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_cycle", bus.cycle, 0);
    chk("rst_retired", bus.retired, 0);
    chk("rst_idle", bus.idle_cnt, 0);
    reset = 1'b0;
    step();
    chk("idle_core_reset", bus.core_reset, 1);

    // basic sequence, one retire per cycle
    start_seq("basic");
    go_run("basic", 2'b01);
    chk("basic_retired", bus.retired, 9);
    chk("basic_hang", bus.hang, 0);
    chk("basic_crst_done", bus.core_reset, 0);
    step();
    chk("basic_done_hold", bus.done, 1);
    chk("basic_ret_frozen", bus.retired, 9);

    // re-arm repeats identical timing
    to_idle("rearm");
    start_seq("rearm");
    go_run("rearm", 2'b01);
    chk("rearm_retired", bus.retired, 9);

    // dual retire
    to_idle("dual");
    start_seq("dual");
    go_run("dual", 2'b11);
    chk("dual_retired", bus.retired, 18);

    // hang with no retirements
    to_idle("hang");
    start_seq("hang");
    for (int c = 0; c <= 8; c++) begin
      chk("hang_idle", bus.idle_cnt, c);
      chk("hang_flag", bus.hang, (c >= 5) ? 1 : 0);
      step();
    end
    chk("hang_final", bus.hang, 1);
    chk("hang_done", bus.done, 1);
    chk("hang_idle_final", bus.idle_cnt, 9);

    // one retire at cycle 3 delays the hang to the check edge
    to_idle("hang2");
    start_seq("hang2");
    for (int c = 0; c <= 8; c++) begin
      chk("hang2_flag", bus.hang, 0);
      bus.rvfi_valid = (c == 3) ? 2'b01 : 2'b00;
      step();
      if (c == 3) chk("hang2_idle_clr", bus.idle_cnt, 0);
    end
    bus.rvfi_valid = 2'b00;
    chk("hang2_idle", bus.idle_cnt, 5);
    chk("hang2_hang", bus.hang, 1);
    chk("hang2_retired", bus.retired, 1);

    // halt before check
    to_idle("halt6");
    start_seq("halt6");
    for (int c = 0; c <= 6; c++) begin
      chk("halt6_check", bus.check, 0);
      bus.rvfi_valid = (c == 6) ? 2'b10 : 2'b00;
      bus.rvfi_halt  = (c == 6) ? 2'b10 : 2'b00;
      step();
    end
    bus.rvfi_valid = 2'b00;
    bus.rvfi_halt  = 2'b00;
    chk("halt6_halted", bus.halted, 1);
    chk("halt6_done", bus.done, 1);
    chk("halt6_retired", bus.retired, 1);
    for (int k = 0; k < 4; k++) begin
      chk("halt6_no_check", bus.check, 0);
      step();
    end

    // halt in the check cycle
    to_idle("halt8");
    start_seq("halt8");
    for (int c = 0; c <= 8; c++) begin
      chk("halt8_check", bus.check, (c == 8) ? 1 : 0);
      bus.rvfi_valid = (c == 8) ? 2'b10 : 2'b00;
      bus.rvfi_halt  = (c == 8) ? 2'b10 : 2'b00;
      step();
    end
    bus.rvfi_valid = 2'b00;
    bus.rvfi_halt  = 2'b00;
    chk("halt8_halted", bus.halted, 1);
    chk("halt8_done", bus.done, 1);

    // abort via enable at cycle 5
    to_idle("abort");
    start_seq("abort");
    for (int c = 0; c < 5; c++) begin
      bus.rvfi_valid = 2'b01;
      step();
    end
    chk("abort_cycle5", bus.cycle, 5);
    chk("abort_ret5", bus.retired, 5);
    bus.enable = 1'b0;
    step();
    chk("abort_crst", bus.core_reset, 1);
    chk("abort_cycle", bus.cycle, 0);
    chk("abort_ret", bus.retired, 0);
    chk("abort_idle", bus.idle_cnt, 0);
    bus.rvfi_valid = 2'b00;

    // async reset between edges
    start_seq("areset");
    for (int c = 0; c < 4; c++) begin
      bus.rvfi_valid = 2'b01;
      step();
    end
    chk("areset_trig_pre", bus.trig, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_crst", bus.core_reset, 1);
    chk("areset_trig", bus.trig, 0);
    chk("areset_cycle", bus.cycle, 0);
    chk("areset_ret", bus.retired, 0);
    step();
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.rvfi_valid = 2'b00;
    step();

    // saturation on the CNT_W=4 instance
    bus2.enable = 1'b1;
    step();
    step();
    step();
    chk("sat_crst", bus2.core_reset, 0);
    for (int c = 0; c <= 10; c++) begin
      chk("sat_check", bus2.check, (c == 10) ? 1 : 0);
      bus2.rvfi_valid = 2'b11;
      step();
    end
    bus2.rvfi_valid = 2'b00;
    chk("sat_retired", bus2.retired, 15);
    chk("sat_done", bus2.done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rvfi_check_sequencer.md
Name: rvfi_check_sequencer

Overview:
- Drives the timing of a formal/simulation check harness: holds the core in reset, then steps through run, trigger and check phases with cycle-accurate `trig`/`check` strobes for the attached rvfi checkers.
- Also counts retirements over the `rvfi_valid` channels and flags hangs (too long without a retirement) and halts.
- Sits between the harness top level and the per-property checker modules. One instance serves all checkers.

Parameters:
- NRET, 1, number of retire channels (width of `rvfi_valid`/`rvfi_halt`).
- RESET_CYCLES, 2, cycles `core_reset` stays high after `enable`; must be >= 1.
- TRIG_CYCLE, 4, run-cycle index at which `trig` pulses.
- CHECK_CYCLE, 8, run-cycle index at which `check` pulses; must be > TRIG_CYCLE.
- HANG_LIMIT, 5, consecutive non-retiring run cycles that set `hang`; must be >= 1.
- CNT_W, 8, counter width; CHECK_CYCLE and HANG_LIMIT must be < 2**CNT_W.
- An illegal parameter combination is an elaboration-time error.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  start/continue sequencing; low returns to IDLE.
- rvfi_valid  in  NRET  per-channel retire valid.
- rvfi_halt  in  NRET  per-channel halt flag, qualified by `rvfi_valid`.
- core_reset  out  1  reset to the DUT core.
- trig  out  1  one-cycle trigger strobe.
- check  out  1  one-cycle check strobe.
- cycle  out  CNT_W  run-cycle index.
- retired  out  CNT_W  saturating retirement count.
- idle_cnt  out  CNT_W  cycles since the last retirement, saturating.
- hang  out  1  sticky hang flag.
- halted  out  1  sticky halt-seen flag.
- done  out  1  sequence finished.

Behaviour:
- **Reset (async, active-high):**
  - state=IDLE; all counters 0; `hang`=`halted`=`done`=0.
  - `core_reset`=1; `trig`=`check`=0.
  - Takes effect immediately, including mid-run.
- **States:** IDLE, RST, RUN, DONE. All registers update on the clock rising edge.
- **IDLE:**
  - `core_reset`=1; counters held at 0.
  - `enable`=1 -> RST, with the reset counter at 0.
- **RST:**
  - `core_reset`=1; the reset counter increments each cycle.
  - After exactly RESET_CYCLES cycles in RST -> RUN, with `cycle`=0.
- **RUN:**
  - `core_reset`=0; `cycle` increments by 1 each cycle.
  - `trig` = (state==RUN && `cycle`==TRIG_CYCLE).
  - `check` = (state==RUN && `cycle`==CHECK_CYCLE).
  - Both strobes are derived from registered state, so each is high for exactly one cycle.
  - In the cycle where `check`=1 -> DONE next cycle.
- **Retire counting (RUN only):**
  - `retired` += popcount(`rvfi_valid`) each cycle, saturating at 2**CNT_W-1.
  - `rvfi_valid` is ignored in all other states.
- **Idle counting (RUN only):**
  - `idle_cnt` is cleared to 0 in any cycle with a nonzero `rvfi_valid`.
  - Otherwise it increments, saturating at 2**CNT_W-1.
  - `hang` sets (sticky) on the edge where `idle_cnt` becomes HANG_LIMIT.
- **Halt:**
  - Any channel with `rvfi_valid` & `rvfi_halt` in RUN -> `halted`=1 (sticky) and DONE next cycle.
  - The halting retirement is counted.
  - If the halt arrives in the `check` cycle, `check` is still 1 that cycle, and `halted`=1.
  - If the halt arrives before CHECK_CYCLE, `check` never pulses.
- **DONE:**
  - `done`=1; `core_reset`=0; all counters and flags frozen.
  - Stays in DONE while `enable`=1.
- **`enable`=0 in RST/RUN/DONE:**
  - -> IDLE next cycle; counters and flags cleared.
  - `core_reset`=1 from that edge onward.
- **`enable`=1 held in IDLE after DONE:** a new sequence starts. There is no auto-restart from DONE.
- **Counter `cycle`:** never wraps, because DONE is entered at CHECK_CYCLE < 2**CNT_W.

Test Plan:
Setup: NRET=2, RESET_CYCLES=2, TRIG_CYCLE=4, CHECK_CYCLE=8, HANG_LIMIT=5, CNT_W=8.
- **Basic sequence:** raise `enable` at edge 0, `rvfi_valid`=2'b01 every RUN cycle -> `core_reset` high through the end of edge 2, falls at edge 3; `trig` high only at `cycle`=4, `check` only at `cycle`=8; `done`=1 next cycle; `retired`=9, `hang`=0.
- **Dual retire and saturation:** `rvfi_valid`=2'b11 every RUN cycle -> `retired`=18. With CNT_W=4 and CHECK_CYCLE=10 -> `retired` saturates at 15.
- **Hang:** `rvfi_valid`=0 throughout RUN -> `idle_cnt` reaches 5 at `cycle`=5 edge and `hang`=1 stays set. A retire at `cycle`=3 instead clears `idle_cnt`, so `hang` sets at `cycle`=8.
- **Halt before check:** `rvfi_valid`[1]=`rvfi_halt`[1]=1 at `cycle`=6 -> `halted`=1, DONE next cycle, `check` never pulses. The same halt at `cycle`=8 -> `check`=1 and `halted`=1.
- **Abort:** `enable`=0 at `cycle`=5 -> IDLE next cycle, `core_reset`=1, counters 0. Asserting async `reset` mid-RUN between clock edges -> outputs return to reset values immediately.
- **Re-arm:** after DONE, drop then raise `enable` -> full sequence repeats with identical strobe timing.
